alu_result_queue: RTL and testbench

//   Downstream stage of the combinational ALU: captures each 24-bit ALU result C

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_result_queue.sv | 88 ++++++++
 tb/tb_alu_result_queue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module  : alu_pkg
//  Purpose : Shared ALU definitions: result width, opcode encodings and the
//            packed result-entry layout used by the ALU and its result queue.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_W = 24;

  localparam logic OP_SUB  = 1'b1;
  localparam logic OP_NONE = 1'b0;

  typedef struct packed {
    logic             sel;
    logic             neg;
    logic             zero;
    logic [ALU_W-1:0] data;
  } alu_entry_t;

  // Flags are derived once, when the result is captured.
  function automatic alu_entry_t make_entry(input logic sel, input logic [ALU_W-1:0] data);
    alu_entry_t e;
    e.sel  = sel;
    e.neg  = data[ALU_W-1];
    e.zero = (data == '0);
    e.data = data;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_result_queue.sv
// ============================================================================
//  Module  : alu_result_queue
//  Purpose : Small FIFO capturing ALU results with opcode and flags, drained
//            by a consumer over a valid/ready handshake.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic [AW:0]      count,
  output logic             drop
);

  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  alu_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_drop;

  logic w_push;
  logic w_pop;

  // No pass-through: a full queue refuses input even while it is being drained.
  assign in_ready  = (r_count != C_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_data = r_mem[r_rd_ptr].data;
  assign out_sel  = r_mem[r_rd_ptr].sel;
  assign out_zero = r_mem[r_rd_ptr].zero;
  assign out_neg  = r_mem[r_rd_ptr].neg;
  assign count    = r_count;
  assign drop     = r_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Sticky overflow indicator; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_drop <= 1'b0;
    else if (in_valid && !in_ready) r_drop <= 1'b1;
  end

  // Storage carries no reset; contents are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (w_push && !flush)
      r_mem[r_wr_ptr] <= make_entry(in_sel, in_data);
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_queue.sv
// ============================================================================
//  Module  : tb_alu_result_queue
//  Purpose : Directed self-checking bench for alu_result_queue.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_sel;
  logic        out_zero;
  logic        out_neg;
  logic [2:0]  count;
  logic        drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_result_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .count     (count),
    .drop      (drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // status vector = {out_valid, count, in_ready, drop}
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, count, in_ready, drop} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b cnt=%0d rdy=%b drop=%b, want v=0 cnt=0 rdy=1 drop=0",
               out_valid, count, in_ready, drop);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 24'h000005; in_sel = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, count, out_data, out_sel, out_zero, out_neg} !==
        {1'b1, 3'd1, 24'h000005, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_push: got v=%b cnt=%0d d=%h s=%b z=%b n=%b, want v=1 cnt=1 d=000005 s=1 z=0 n=0",
               out_valid, count, out_data, out_sel, out_zero, out_neg);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL single_pop: got v=%b cnt=%0d, want v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_fill_drop();
    logic [23:0] vals [4];
    logic [1:0]  flg  [4]; // {neg, zero}
    vals = '{24'hFFFFFE, 24'h000000, 24'h000001, 24'h7FFFFF};
    flg  = '{2'b10, 2'b01, 2'b00, 2'b00};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vals[i]; in_sel = 1'(i & 1);
      step();
    end
    n_checks++;
    if ({count, in_ready, drop} !== {3'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fill_full: got cnt=%0d rdy=%b drop=%b, want cnt=4 rdy=0 drop=0", count, in_ready, drop);
    end
    in_data = 24'h123456;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({count, drop} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_drop: got cnt=%0d drop=%b, want cnt=4 drop=1", count, drop);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({out_valid, out_data, out_sel, out_neg, out_zero} !== {1'b1, vals[i], 1'(i & 1), flg[i]}) begin
        n_fail++;
        $display("FAIL drain_%0d: got v=%b d=%h s=%b n=%b z=%b, want v=1 d=%h s=%b nz=%b",
                 i, out_valid, out_data, out_sel, out_neg, out_zero, vals[i], 1'(i & 1), flg[i]);
      end
      step();
    end
    step(); // out_ready held while empty
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL drain_empty: got v=%b cnt=%0d rdy=%b, want v=0 cnt=0 rdy=1", out_valid, count, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      in_data = 24'h000100 + 24'(j); in_sel = 1'b0;
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 24'h000102 + 24'(i);
      n_checks++;
      if ({out_valid, count, out_data} !== {1'b1, 3'd2, 24'h000100 + 24'(i)}) begin
        n_fail++;
        $display("FAIL steady_%0d: got v=%b cnt=%0d d=%h, want v=1 cnt=2 d=%h",
                 i, out_valid, count, out_data, 24'h000100 + 24'(i));
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({count, out_data} !== {3'd2, 24'h00010A}) begin
      n_fail++;
      $display("FAIL steady_end: got cnt=%0d d=%h, want cnt=2 d=00010a", count, out_data);
    end
  endtask

  task automatic test_full_poppush();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_data = 24'h000010 + 24'(j);
      step();
    end
    in_data = 24'h0000AA; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({count, drop, in_ready, out_data} !== {3'd3, 1'b1, 1'b1, 24'h000011}) begin
      n_fail++;
      $display("FAIL full_pop_push: got cnt=%0d drop=%b rdy=%b d=%h, want cnt=3 drop=1 rdy=1 d=000011",
               count, drop, in_ready, out_data);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; in_valid = 1'b1; in_data = 24'h0000BB; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({out_valid, count, in_ready, drop} !== {1'b0, 3'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL flush: got v=%b cnt=%0d rdy=%b drop=%b, want v=0 cnt=0 rdy=1 drop=1",
               out_valid, count, in_ready, drop);
    end
    in_valid = 1'b1; in_data = 24'h800000; in_sel = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({count, out_data, out_neg, out_zero} !== {3'd1, 24'h800000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL post_flush_push: got cnt=%0d d=%h n=%b z=%b, want cnt=1 d=800000 n=1 z=0",
               count, out_data, out_neg, out_zero);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 24'h000042;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, count, in_ready, drop} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b cnt=%0d rdy=%b drop=%b, want v=0 cnt=0 rdy=1 drop=0",
               out_valid, count, in_ready, drop);
    end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drop();
    test_back_to_back();
    test_full_poppush();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
